// File: rtl/common_pseudo_lru_way_allocator_pkg.sv
// Shared definitions for the pseudo-LRU way allocator: FSM state codes and
// the default way count. No ports.
package common_lru_defs;

  localparam int unsigned DEF_WAY_COUNT_LOG2 = 3;
  localparam int unsigned P_COUNT            = 1 << DEF_WAY_COUNT_LOG2;

  // Allocator FSM encoding; code 3 is unused and recovers to IDLE.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PICK  = 2'd1;
  localparam logic [1:0] S_GRANT = 2'd2;

endpackage

// File: rtl/common_pseudo_lru_way_allocator_if.sv
// Allocation handshake plus hit/invalidate/flush side-band for the way allocator.
//   master: miss/refill + lookup logic (drives requests, commits, touch, inv, flush)
//   slave : the allocator (drives ready, grant way/victim, occupancy)
interface common_pseudo_lru_way_allocator_if #(
  parameter int unsigned N = 8
);

  logic         alloc_req_valid;
  logic         alloc_req_ready;
  logic         alloc_grant_valid;
  logic         alloc_grant_ready;
  logic [N-1:0] alloc_grant_way;
  logic         alloc_grant_victim;
  logic         touch_en;
  logic [N-1:0] touch_way;
  logic         inv_en;
  logic [N-1:0] inv_way;
  logic         flush;
  logic [N-1:0] occupied;

  modport master (
    output alloc_req_valid, alloc_grant_ready, touch_en, touch_way,
           inv_en, inv_way, flush,
    input  alloc_req_ready, alloc_grant_valid, alloc_grant_way,
           alloc_grant_victim, occupied
  );

  modport slave (
    input  alloc_req_valid, alloc_grant_ready, touch_en, touch_way,
           inv_en, inv_way, flush,
    output alloc_req_ready, alloc_grant_valid, alloc_grant_way,
           alloc_grant_victim, occupied
  );

endinterface

// File: rtl/common_pseudo_lru_way_allocator_tree.sv
// Tree pseudo-LRU state: N-1 node bits in heap order (node 0 = root).
//   clk, resetn            : clock, async active-low reset
//   flush                  : clear all node bits
//   touch_en/touch_way     : hit touch (one-hot)
//   commit_en/commit_way   : grant commit touch, applied after the hit touch
//   victim_way_c           : one-hot victim from the post-update tree (combinational)
module common_pseudo_lru_tree_state
  import common_lru_defs::*;
#(
  parameter  int unsigned WAY_COUNT_LOG2 = DEF_WAY_COUNT_LOG2,
  localparam int unsigned N              = 1 << WAY_COUNT_LOG2,
  localparam int unsigned TW             = N - 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         touch_en,
  input  logic [N-1:0] touch_way,
  input  logic         commit_en,
  input  logic [N-1:0] commit_way,
  output logic [N-1:0] victim_way_c
);

  logic [TW-1:0] tree_q;
  logic [TW-1:0] tree_d;

  function automatic logic [WAY_COUNT_LOG2-1:0] way_index(input logic [N-1:0] w);
    logic [WAY_COUNT_LOG2-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (w[i]) idx = idx | WAY_COUNT_LOG2'(i);
    end
    return idx;
  endfunction

  // Point every node on w's path away from w; the index MSB selects the half.
  function automatic logic [TW-1:0] tree_touch(input logic [TW-1:0] t_in,
                                               input logic [N-1:0]  w);
    logic [TW-1:0]             t;
    logic [WAY_COUNT_LOG2-1:0] path;
    int                        node;
    t    = t_in;
    path = way_index(w);
    node = 0;
    for (int lvl = 0; lvl < int'(WAY_COUNT_LOG2); lvl++) begin
      for (int n = 0; n < int'(TW); n++) begin
        if (n == node) t[n] = ~path[WAY_COUNT_LOG2-1];
      end
      node = 2 * node + (path[WAY_COUNT_LOG2-1] ? 2 : 1);
      path = path << 1;
    end
    return t;
  endfunction

  // Next tree: flush, then hit touch, then commit touch (commit wins shared nodes).
  always_comb begin
    tree_d = tree_q;
    if (flush) begin
      tree_d = '0;
    end else if (touch_en) begin
      tree_d = tree_touch(tree_d, touch_way);
    end
    if (commit_en) tree_d = tree_touch(tree_d, commit_way);
  end

  // Victim walk from the root over the post-update tree.
  always_comb begin
    int                        node;
    logic [WAY_COUNT_LOG2-1:0] idx;
    logic                      b;
    node = 0;
    idx  = '0;
    b    = 1'b0;
    for (int lvl = 0; lvl < int'(WAY_COUNT_LOG2); lvl++) begin
      b = 1'b0;
      for (int n = 0; n < int'(TW); n++) begin
        if (n == node) b = tree_d[n];
      end
      idx  = (idx << 1) | WAY_COUNT_LOG2'(b);
      node = 2 * node + (b ? 2 : 1);
    end
    victim_way_c = N'(1) << idx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tree_q <= '0;
    else         tree_q <= tree_d;
  end

endmodule

// File: rtl/common_pseudo_lru_way_allocator.sv
// Way allocator for a fully-associative structure: occupancy tracking,
// free-way priority pick with tree-PLRU fallback, request/grant handshake.
//   clk, resetn : clock, async active-low reset
//   bus         : allocator slave side (request, grant, touch, inv, flush, occupied)
module common_pseudo_lru_way_allocator
  import common_lru_defs::*;
#(
  parameter int unsigned WAY_COUNT_LOG2 = DEF_WAY_COUNT_LOG2
) (
  input logic                              clk,
  input logic                              resetn,
  common_pseudo_lru_way_allocator_if.slave bus
);

  localparam int unsigned N = 1 << WAY_COUNT_LOG2;

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic         commit_c;
  logic [N-1:0] occ_q;
  logic [N-1:0] occ_d;
  logic [N-1:0] free_way_c;
  logic [N-1:0] victim_way_c;
  logic         any_free_c;
  logic [N-1:0] grant_way_q;
  logic         grant_victim_q;
  logic         req_ready_q;
  logic         grant_valid_q;

  // Next-state logic; commit happens on the grant handshake.
  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.alloc_req_valid) state_d = S_PICK;
      S_PICK:  state_d = S_GRANT;
      S_GRANT: begin
        if (bus.alloc_grant_ready) begin
          commit_c = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy: flush, then inv, then commit (commit beats inv on the same way).
  always_comb begin
    occ_d = occ_q;
    if (bus.flush) begin
      occ_d = '0;
    end else if (bus.inv_en) begin
      occ_d = occ_d & ~bus.inv_way;
    end
    if (commit_c) occ_d = occ_d | grant_way_q;
  end

  // Lowest-index free way after same-cycle updates.
  always_comb begin
    logic found;
    free_way_c = '0;
    found      = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!occ_d[i] && !found) begin
        free_way_c[i] = 1'b1;
        found         = 1'b1;
      end
    end
    any_free_c = ~&occ_d;
  end

  common_pseudo_lru_tree_state #(
    .WAY_COUNT_LOG2 (WAY_COUNT_LOG2)
  ) u_tree (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (bus.flush),
    .touch_en     (bus.touch_en),
    .touch_way    (bus.touch_way),
    .commit_en    (commit_c),
    .commit_way   (grant_way_q),
    .victim_way_c (victim_way_c)
  );

  // State, handshake flags, grant payload (captured only in PICK) and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      req_ready_q    <= 1'b1;
      grant_valid_q  <= 1'b0;
      grant_way_q    <= '0;
      grant_victim_q <= 1'b0;
      occ_q          <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= (state_d == S_IDLE);
      grant_valid_q <= (state_d == S_GRANT);
      occ_q         <= occ_d;
      if (state_q == S_PICK) begin
        grant_way_q    <= any_free_c ? free_way_c : victim_way_c;
        grant_victim_q <= ~any_free_c;
      end
    end
  end

  assign bus.alloc_req_ready    = req_ready_q;
  assign bus.alloc_grant_valid  = grant_valid_q;
  assign bus.alloc_grant_way    = grant_way_q;
  assign bus.alloc_grant_victim = grant_victim_q;
  assign bus.occupied           = occ_q;

endmodule

// File: tb/tb_common_pseudo_lru_way_allocator.sv
// Self-checking bench for common_pseudo_lru_way_allocator with a reference
// model that predicts each grant at pick time into a scoreboard queue.
module tb_common_pseudo_lru_way_allocator;
  import common_lru_defs::*;

  localparam int unsigned N   = P_COUNT;
  localparam int unsigned TIW = $clog2(N - 1);

  typedef struct packed {
    logic [N-1:0] way;
    logic         victim;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  common_pseudo_lru_way_allocator_if #(.N(N)) bus ();

  common_pseudo_lru_way_allocator #(.WAY_COUNT_LOG2(DEF_WAY_COUNT_LOG2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] m_occ;
  logic [N-2:0] m_tree;
  logic [1:0]   m_state;
  logic [N-1:0] m_way;
  exp_t         sb[$];

  function automatic logic [N-2:0] m_touch(input logic [N-2:0] t_in, input logic [N-1:0] w);
    logic [N-2:0] t;
    int idx, node, lo, size, half;
    t = t_in; idx = 0; node = 0; lo = 0; size = int'(N);
    for (int i = 0; i < int'(N); i++) if (w[i]) idx = i;
    while (size > 1) begin
      half = size / 2;
      if (idx < lo + half) begin
        t[TIW'(node)] = 1'b1;
        node = 2 * node + 1;
      end else begin
        t[TIW'(node)] = 1'b0;
        node = 2 * node + 2;
        lo   = lo + half;
      end
      size = half;
    end
    return t;
  endfunction

  function automatic logic [N-1:0] m_victim(input logic [N-2:0] t);
    int node, lo, size, half;
    node = 0; lo = 0; size = int'(N);
    while (size > 1) begin
      half = size / 2;
      if (t[TIW'(node)] == 1'b0) begin
        node = 2 * node + 1;
      end else begin
        node = 2 * node + 2;
        lo   = lo + half;
      end
      size = half;
    end
    return N'(1) << lo;
  endfunction

  function automatic logic [N-1:0] m_free(input logic [N-1:0] o);
    for (int i = 0; i < int'(N); i++) if (!o[i]) return N'(1) << i;
    return '0;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_occ   <= '0;
      m_tree  <= '0;
      m_state <= S_IDLE;
      m_way   <= '0;
      sb.delete();
    end else begin
      logic [N-1:0] o;
      logic [N-2:0] t;
      exp_t         e;
      o = m_occ;
      t = m_tree;
      if (bus.flush) begin
        o = '0;
        t = '0;
      end else begin
        if (bus.inv_en)   o = o & ~bus.inv_way;
        if (bus.touch_en) t = m_touch(t, bus.touch_way);
      end
      case (m_state)
        S_IDLE: if (bus.alloc_req_valid) m_state <= S_PICK;
        S_PICK: begin
          if (o != {N{1'b1}}) begin
            e.way = m_free(o); e.victim = 1'b0;
          end else begin
            e.way = m_victim(t); e.victim = 1'b1;
          end
          sb.push_back(e);
          m_way   <= e.way;
          m_state <= S_GRANT;
        end
        S_GRANT: begin
          if (bus.alloc_grant_ready) begin
            o = o | m_way;
            t = m_touch(t, m_way);
            m_state <= S_IDLE;
          end
        end
        default: m_state <= S_IDLE;
      endcase
      m_occ  <= o;
      m_tree <= t;
    end
  end

  // ---------------- output checker ----------------
  logic prev_gv = 1'b0;
  exp_t cur;

  always @(negedge clk) begin
    exp_t e;
    check("req_ready",   32'(bus.alloc_req_ready),   32'(m_state == S_IDLE));
    check("grant_valid", 32'(bus.alloc_grant_valid), 32'(m_state == S_GRANT));
    check("occupied",    32'(bus.occupied),          32'(m_occ));
    if (bus.alloc_grant_valid && !prev_gv) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("grant_way",    32'(bus.alloc_grant_way),    32'(e.way));
        check("grant_victim", 32'(bus.alloc_grant_victim), 32'(e.victim));
        cur <= e;
      end
    end else if (bus.alloc_grant_valid) begin
      check("grant_way_stable",    32'(bus.alloc_grant_way),    32'(cur.way));
      check("grant_victim_stable", 32'(bus.alloc_grant_victim), 32'(cur.victim));
    end
    prev_gv <= bus.alloc_grant_valid;
  end

  // ---------------- stimulus ----------------
  task automatic clear_side();
    bus.touch_en = 1'b0; bus.touch_way = '0;
    bus.inv_en   = 1'b0; bus.inv_way   = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic rand_side();
    bus.touch_en  = 1'($urandom_range(0, 1));
    bus.touch_way = N'(1) << $urandom_range(0, N - 1);
    bus.inv_en    = 1'($urandom_range(0, 1));
    bus.inv_way   = N'(1) << $urandom_range(0, N - 1);
    bus.flush     = ($urandom_range(0, 15) == 0);
  endtask

  task automatic pulse(input bit t_en, input int t_w, input bit i_en, input int i_w);
    @(posedge clk); #1;
    bus.touch_en = t_en; bus.touch_way = N'(1) << t_w;
    bus.inv_en   = i_en; bus.inv_way   = N'(1) << i_w;
    @(posedge clk); #1;
    clear_side();
  endtask

  // mode 0: plain, 1: touch/inv granted way while stalled,
  // 2: touch granted way on commit cycle, 3: flush on commit cycle, 4: random side-band
  task automatic alloc(input int stall, input int mode);
    int k;
    bus.alloc_grant_ready = (stall == 0);
    @(posedge clk); #1;
    bus.alloc_req_valid = 1'b1;
    if (mode == 4) rand_side();
    @(posedge clk); #1;
    bus.alloc_req_valid = 1'b0;
    if (mode == 4) rand_side(); else clear_side();
    k = 0;
    while (!bus.alloc_grant_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("grant_seen", 32'(bus.alloc_grant_valid), 32'(1));
    if (stall == 0 && mode == 2) begin
      bus.touch_en = 1'b1; bus.touch_way = m_way;
    end
    if (stall == 0 && mode == 3) bus.flush = 1'b1;
    for (int s = 0; s < stall; s++) begin
      clear_side();
      if (mode == 1) begin
        bus.touch_en = s[0];  bus.touch_way = m_way;
        bus.inv_en   = ~s[0]; bus.inv_way   = m_way;
      end
      if (mode == 4) rand_side();
      @(negedge clk);
    end
    if (stall != 0) begin
      clear_side();
      if (mode == 4) rand_side();
    end
    bus.alloc_grant_ready = 1'b1;
    @(posedge clk); #1;
    bus.alloc_grant_ready = 1'b0;
    clear_side();
  endtask

  initial begin
    int k;
    bus.alloc_req_valid = 1'b0;
    bus.alloc_grant_ready = 1'b0;
    clear_side();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready",    32'(bus.alloc_req_ready),    32'(1));
    check("rst_grant_valid",  32'(bus.alloc_grant_valid),  32'(0));
    check("rst_grant_way",    32'(bus.alloc_grant_way),    32'(0));
    check("rst_grant_victim", 32'(bus.alloc_grant_victim), 32'(0));
    check("rst_occupied",     32'(bus.occupied),           32'(0));
    resetn = 1'b1;

    // fill from reset: ways 0..7 in order
    for (int i = 0; i < int'(N); i++) begin
      alloc(0, 0);
      check("fill_way", 32'(cur.way), 32'(N'(1) << i));
      check("fill_victim", 32'(cur.victim), 32'(0));
    end
    check("fill_occupied", 32'(bus.occupied), 32'h0000_00FF);

    alloc(0, 0);
    check("plru_way0", 32'(cur.way), 32'h01);
    check("plru_victim0", 32'(cur.victim), 32'(1));
    pulse(1'b1, 0, 1'b0, 0);
    alloc(0, 0);
    check("plru_way4", 32'(cur.way), 32'h10);
    check("plru_victim4", 32'(cur.victim), 32'(1));

    pulse(1'b0, 0, 1'b1, 5);
    alloc(0, 0);
    check("inv_way5", 32'(cur.way), 32'h20);
    check("inv_victim5", 32'(cur.victim), 32'(0));
    pulse(1'b0, 0, 1'b1, 2);
    pulse(1'b0, 0, 1'b1, 6);
    alloc(0, 0);
    check("inv_lowest_way2", 32'(cur.way), 32'h04);

    // backpressure: way 6 still free, held 5 cycles while touched/invalidated
    alloc(5, 1);
    check("bp_way6", 32'(cur.way), 32'h40);
    check("bp_occupied6", 32'(bus.occupied[6]), 32'(1));

    pulse(1'b0, 0, 1'b1, 3);
    alloc(0, 2);
    check("touch_commit_way3", 32'(cur.way), 32'h08);

    pulse(1'b0, 0, 1'b1, 6);
    alloc(0, 3);
    check("flush_commit_way6", 32'(cur.way), 32'h40);
    check("flush_commit_occ", 32'(bus.occupied), 32'h40);

    for (int r = 0; r < 30; r++) alloc($urandom_range(0, 3), 4);

    // reset while a grant is held
    bus.alloc_grant_ready = 1'b0;
    @(posedge clk); #1;
    bus.alloc_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.alloc_req_valid = 1'b0;
    k = 0;
    while (!bus.alloc_grant_valid && k < 8) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_grant_seen", 32'(bus.alloc_grant_valid), 32'(1));
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check("rst_mid_grant_valid", 32'(bus.alloc_grant_valid), 32'(0));
    check("rst_mid_occupied",    32'(bus.occupied),          32'(0));
    @(negedge clk);
    resetn = 1'b1;
    alloc(0, 0);
    check("post_rst_way", 32'(cur.way), 32'h01);
    check("post_rst_victim", 32'(cur.victim), 32'(0));

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/common_pseudo_lru_way_allocator.md
# common_pseudo_lru_way_allocator

Way-allocation scheduler for a single fully-associative structure (TLB, fill buffer, victim cache) of 2^WAY_COUNT_LOG2 ways. It tracks per-way occupancy and a tree pseudo-LRU state, and serves one allocation request at a time through a request/grant handshake. Each grant carries a one-hot way: a free way if one exists, otherwise the PLRU victim. It sits between the miss/refill logic, which requests and commits ways, and the lookup logic, which touches ways on hit and invalidates them.

## Interface
- WAY_COUNT_LOG2, 3, log2 of way count N; legal range 1..5.
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- alloc_req_valid  in  1  allocation request.
- alloc_req_ready  out  1  request accepted when both valid and ready are high.
- alloc_grant_valid  out  1  grant presented.
- alloc_grant_ready  in  1  consumer commits the grant.
- alloc_grant_way  out  N  one-hot granted way.
- alloc_grant_victim  out  1  granted way was occupied at pick time (eviction required).
- touch_en  in  1  hit access.
- touch_way  in  N  one-hot way touched; ignored unless touch_en.
- inv_en  in  1  invalidate.
- inv_way  in  N  one-hot way to clear.
- flush  in  1  clear all occupancy and PLRU state.
- occupied  out  N  registered occupancy vector.

## Operation
- FSM states: IDLE, PICK, GRANT. Encoding is 2 bits: IDLE=0, PICK=1, GRANT=2. The unused code 3 returns to IDLE.
- IDLE:
  - alloc_req_ready=1.
  - On alloc_req_valid, go to PICK.
- PICK:
  - alloc_req_ready=0.
  - Compute the choice from current-cycle state, after applying same-cycle touch/inv/flush, and register it.
  - Go to GRANT.
- Choice rule:
  - If any way is unoccupied, choose the lowest-index unoccupied way with victim=0.
  - Otherwise walk the PLRU tree from the root, with victim=1.
- GRANT:
  - alloc_grant_valid=1.
  - alloc_grant_way and alloc_grant_victim stay stable until alloc_grant_ready.
  - On alloc_grant_ready, set occupied[way]=1, touch the way in the PLRU, and go to IDLE.
- PLRU tree:
  - N-1 node bits in heap order; node 0 is the root.
  - Bit 0 means the victim lies in the lower-index half; bit 1 means the upper half.
- Touching way w sets every node on w's path to point away from w: bit=1 if w is in the node's lower half.
- Touch and inv apply in any state. Flush clears all occupancy bits and all tree bits.
- Same-cycle precedence:
  - Touch and grant commit: the touch is applied first and the commit second, so the commit wins on shared nodes.
  - inv and commit on the same way: the way ends occupied.
  - flush and commit: flush is applied first, then the commit sets its way and touches it.
  - inv or touch with flush: flush wins.
- A held grant is never re-picked. If the granted way is invalidated or flushed during GRANT, alloc_grant_way and alloc_grant_victim are unchanged.
- Non-one-hot touch_way or inv_way: every set bit is cleared for inv. For touch the result is undefined; the bench must not drive this.

## Timing
- Reset values:
  - State IDLE; alloc_req_ready=1, alloc_grant_valid=0.
  - alloc_grant_way=0, alloc_grant_victim=0.
  - occupied=0, all tree bits 0.
- resetn assertion takes effect immediately (asynchronous). A grant in flight is dropped without commit.
- Latency: request accepted at cycle T, alloc_grant_valid high at T+2. The earliest next acceptance is the cycle after commit.
- Throughput is one allocation per 3 cycles with no backpressure.
- All outputs are registered; there is no combinational path from inputs to outputs.
- occupied and PLRU updates are visible from the cycle after the event.

## Structure
- Shared package/include `common_lru_defs`: FSM state codes and the localparam P_COUNT = 1 << WAY_COUNT_LOG2.
- Sub-module `common_pseudo_lru_tree_state`: owns the N-1 node register (async active-low reset).
  - Ports: clk, resetn, flush, a touch port, a commit-touch port (commit applied second), and a combinational victim one-hot output.
- The top level holds the FSM, the occupancy register, the free-way priority encoder and the grant registers.

## Test plan
- Fill from reset (N=8): eight request/commit pairs with alloc_grant_ready high. Required: ways 0..7 granted in order, victim=0, grant_valid at T+2 each time; occupied=8'hFF.
- PLRU victim: after the fill, request again. Required: way 0 (8'h01), victim=1. Commit it, touch way 0, request again. Required: way 4 (8'h10), victim=1.
- Invalidate while full: inv way 5, then request. Required: way 5 (8'h20), victim=0. With ways 2 and 6 invalidated, the grant is way 2.
- Backpressure: hold alloc_grant_ready=0 for 5 cycles while touching and invalidating the granted way. Required:
  - alloc_grant_way and alloc_grant_victim stay stable.
  - alloc_req_ready stays 0.
  - On commit the way is occupied.
- Simultaneous events: touch way 3 and commit of way 3 in one cycle produce the same tree as a commit alone. flush together with commit of way 6 leaves occupied=8'h40.
- Reset mid-GRANT: drop resetn asynchronously between clock edges. Required: alloc_grant_valid=0 and occupied=0 immediately. After release the next grant is way 0, victim=0.
